multicycle_ctrl: RTL and testbench

//  Main control FSM for the multi-cycle MIPS CPU. Sequences the datapath each instruction:
//  PC, IR, MDR, A/B and ALUOut registers, register file, memory port and ALU muxes.

---
 rtl/multicycle_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose:
//   Main control FSM for a multi-cycle MIPS CPU. Each instruction is
//   sequenced through a chain of states, and every datapath enable and mux
//   select is driven from here: PC, IR, MDR, A/B, ALUOut, register file,
//   memory port and ALU operand muxes. Memory accesses use a ready
//   handshake, so instruction fetch, loads and stores stall until memory
//   signals completion. Decodes R-type, lw, sw, beq, j and addi.
//
// Optional feature (compile-time macro CTRL_TRAP_EN):
//   defined   - an illegal opcode in DECODE enters TRAP, which raises
//               illegal_instr and holds every other output low until rst.
//   undefined - an illegal opcode retires as a NOP from DECODE (PC has
//               already advanced), and the illegal_instr port is absent.
//
// Parameters:
//   OPC_W    opcode width (IR[31:26])
//   STATE_W  state register width
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset
//   opcode         in   IR[31:26], valid from DECODE onward
//   zero           in   ALU zero flag, used in BRANCH
//   mem_ready      in   memory completes the current access this cycle
//   pc_en          out  PC load enable
//   iord           out  memory address select (0: PC, 1: ALUOut)
//   mem_read       out  memory read request
//   mem_write      out  memory write request
//   ir_write       out  IR load enable
//   reg_write      out  register file write enable
//   reg_dst        out  write register select (0: rt, 1: rd)
//   mem_to_reg     out  write-back select (0: ALUOut, 1: MDR)
//   alu_src_a      out  ALU A select (0: PC, 1: A)
//   alu_src_b      out  ALU B select (0: B, 1: 4, 2: imm, 3: imm << 2)
//   alu_op         out  ALU operation (0: add, 1: sub, 2: funct field)
//   pc_source      out  PC source (0: ALU result, 1: ALUOut, 2: jump target)
//   state          out  current state, for debug
//   instr_done     out  one-cycle pulse on the last cycle of an instruction
//   illegal_instr  out  high while trapped (CTRL_TRAP_EN builds only)
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int OPC_W   = 6,
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [OPC_W-1:0]   opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_en,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [STATE_W-1:0] state,
  output logic               instr_done
`ifdef CTRL_TRAP_EN
  ,
  output logic               illegal_instr
`endif
);

  // State encoding is fixed because the state code is visible on the debug
  // port; codes 13-15 have no name and fall back to FETCH.
  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEM_ADDR = STATE_W'(2),
    S_MEM_RD   = STATE_W'(3),
    S_MEM_WB   = STATE_W'(4),
    S_MEM_WR   = STATE_W'(5),
    S_R_EXEC   = STATE_W'(6),
    S_R_WB     = STATE_W'(7),
    S_BRANCH   = STATE_W'(8),
    S_JUMP     = STATE_W'(9),
    S_I_EXEC   = STATE_W'(10),
    S_I_WB     = STATE_W'(11),
    S_TRAP     = STATE_W'(12)
  } state_t;

  // Primary opcodes understood by this controller.
  localparam logic [OPC_W-1:0] OP_RTYPE = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW    = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW    = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_J     = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_ADDI  = OPC_W'(6'b001000);

  state_t state_q;
  state_t state_d;

  logic opRtype;
  logic opLoad;
  logic opStore;
  logic opBeq;
  logic opJump;
  logic opAddi;
  logic opLegal;

  // Opcode class flags. Only meaningful from DECODE onward, which is the
  // only place the FSM looks at them.
  always_comb begin
    opRtype = (opcode == OP_RTYPE);
    opLoad  = (opcode == OP_LW);
    opStore = (opcode == OP_SW);
    opBeq   = (opcode == OP_BEQ);
    opJump  = (opcode == OP_J);
    opAddi  = (opcode == OP_ADDI);
    opLegal = opRtype | opLoad | opStore | opBeq | opJump | opAddi;
  end

  // State register. Reset wins over everything, including a pending memory
  // handshake, so an access in flight is simply abandoned.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Memory states hold until mem_ready; every other state
  // advances unconditionally. The trap state only exists as a case item in
  // trap builds, so in the default build code 12 lands in the default arm
  // and recovers to FETCH like the other unused codes.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH: begin
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        if (opRtype) begin
          state_d = S_R_EXEC;
        end else if (opLoad || opStore) begin
          state_d = S_MEM_ADDR;
        end else if (opBeq) begin
          state_d = S_BRANCH;
        end else if (opJump) begin
          state_d = S_JUMP;
        end else if (opAddi) begin
          state_d = S_I_EXEC;
        end else begin
`ifdef CTRL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
`endif
        end
      end
      S_MEM_ADDR: begin
        state_d = opStore ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        state_d = mem_ready ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        state_d = S_FETCH;
      end
      S_MEM_WR: begin
        state_d = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_R_EXEC: begin
        state_d = S_R_WB;
      end
      S_R_WB: begin
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
      end
      S_JUMP: begin
        state_d = S_FETCH;
      end
      S_I_EXEC: begin
        state_d = S_I_WB;
      end
      S_I_WB: begin
        state_d = S_FETCH;
      end
`ifdef CTRL_TRAP_EN
      S_TRAP: begin
        state_d = S_TRAP;
      end
`endif
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Output decode. Everything defaults low and each state raises only what
  // it needs. The few Mealy terms are the handshake-qualified enables in
  // FETCH and MEM_WR, the zero-qualified PC load in BRANCH, and (in the
  // default build) the NOP retirement pulse for an illegal opcode in DECODE.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    pc_source  = 2'd0;
    instr_done = 1'b0;
`ifdef CTRL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        // PC + 4 is computed every fetch cycle but only committed together
        // with the IR once memory actually returns the instruction.
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target (PC + imm << 2) is parked in ALUOut.
        alu_src_b = 2'd3;
`ifndef CTRL_TRAP_EN
        instr_done = ~opLegal;
`endif
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        // Compare A - B; the target computed in DECODE comes from ALUOut.
        alu_src_a  = 1'b1;
        alu_op     = 2'd1;
        pc_source  = 2'd1;
        pc_en      = zero;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_source  = 2'd2;
        pc_en      = 1'b1;
        instr_done = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
`ifdef CTRL_TRAP_EN
      S_TRAP: begin
        illegal_instr = 1'b1;
      end
`endif
      default: begin
      end
    endcase
  end

  // Debug view of the current state.
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. A table of per-instruction state
// paths, a few hand-written handshake/reset sequences, and a randomized run
// whose expected per-cycle behaviour is built from each instruction's phase
// list (fetch, decode, class-specific phases, memory stalls).
// Compile with CTRL_TRAP_EN to exercise the trap build.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, iord, mem_read, mem_write, ir_write, reg_write;
  logic       reg_dst, mem_to_reg, alu_src_a, instr_done;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
`ifdef CTRL_TRAP_EN
  logic       illegal_instr;
`endif

  logic [15:0] dutCtrl;

  int checks = 0;
  int errors = 0;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  multicycle_ctrl #(.OPC_W(6), .STATE_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .opcode(opcode),
    .zero(zero),
    .mem_ready(mem_ready),
    .pc_en(pc_en),
    .iord(iord),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .ir_write(ir_write),
    .reg_write(reg_write),
    .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg),
    .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b),
    .alu_op(alu_op),
    .pc_source(pc_source),
    .state(state),
    .instr_done(instr_done)
`ifdef CTRL_TRAP_EN
    ,
    .illegal_instr(illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  // Every control output packed into one word for whole-cycle comparison.
  assign dutCtrl = {pc_en, iord, mem_read, mem_write, ir_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
                    pc_source, instr_done};

  typedef struct {
    int   st;
    logic rdy;
  } cyc_t;

  typedef struct {
    logic [5:0]  op;
    logic        z;
    int          len;
    logic [31:0] path;
    logic        pcEnLast;
    logic        regWrLast;
  } vec_t;

  // One comparison: counts it, reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive a cycle's inputs half a period before the next rising edge, then
  // let the combinational outputs settle before anything is sampled.
  task automatic applyStimulus(input logic r, input logic [5:0] op,
                               input logic z, input logic rdy);
    @(negedge clk);
    rst       = r;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    #1;
  endtask

  // Two reset edges; the following applyStimulus starts in FETCH.
  task automatic doReset();
    applyStimulus(1'b1, OP_R, 1'b0, 1'b1);
    applyStimulus(1'b1, OP_R, 1'b0, 1'b1);
    checkOutput("reset_state", state, 0);
  endtask

  function automatic logic isLegal(input logic [5:0] op);
    return (op == OP_R) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

  // Expected control word for a cycle spent in the given phase.
  function automatic logic [15:0] expectCtrl(input int st, input logic [5:0] op,
                                             input logic z, input logic rdy);
    logic pe, io, mr, mw, iw, rw, rd, m2r, sa, dn;
    logic [1:0] sb, ao, ps;
    pe = 0; io = 0; mr = 0; mw = 0; iw = 0; rw = 0; rd = 0; m2r = 0; sa = 0; dn = 0;
    sb = 0; ao = 0; ps = 0;
    case (st)
      0:  begin mr = 1; sb = 1; iw = rdy; pe = rdy; end
      1:  begin sb = 3;
`ifndef CTRL_TRAP_EN
                dn = !isLegal(op);
`endif
          end
      2:  begin sa = 1; sb = 2; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; dn = 1; end
      5:  begin mw = 1; io = 1; dn = rdy; end
      6:  begin sa = 1; ao = 2; end
      7:  begin rw = 1; rd = 1; dn = 1; end
      8:  begin sa = 1; ao = 1; ps = 1; pe = z; dn = 1; end
      9:  begin ps = 2; pe = 1; dn = 1; end
      10: begin sa = 1; sb = 2; end
      11: begin rw = 1; dn = 1; end
      default: begin end
    endcase
    return {pe, io, mr, mw, iw, rw, rd, m2r, sa, sb, ao, ps, dn};
  endfunction

  // Reference: expand one instruction into its cycle-by-cycle phases, with
  // the requested number of memory stalls, then run and compare each cycle.
  task automatic runModelInstr(input logic [5:0] op, input logic z,
                               input int fStall, input int mStall);
    cyc_t seq[$];
    for (int k = 0; k < fStall; k++) seq.push_back('{0, 1'b0});
    seq.push_back('{0, 1'b1});
    seq.push_back('{1, 1'($urandom_range(0, 1))});
    if (op == OP_R) begin
      seq.push_back('{6, 1'($urandom_range(0, 1))});
      seq.push_back('{7, 1'($urandom_range(0, 1))});
    end else if (op == OP_LW) begin
      seq.push_back('{2, 1'($urandom_range(0, 1))});
      for (int k = 0; k < mStall; k++) seq.push_back('{3, 1'b0});
      seq.push_back('{3, 1'b1});
      seq.push_back('{4, 1'($urandom_range(0, 1))});
    end else if (op == OP_SW) begin
      seq.push_back('{2, 1'($urandom_range(0, 1))});
      for (int k = 0; k < mStall; k++) seq.push_back('{5, 1'b0});
      seq.push_back('{5, 1'b1});
    end else if (op == OP_BEQ) begin
      seq.push_back('{8, 1'($urandom_range(0, 1))});
    end else if (op == OP_J) begin
      seq.push_back('{9, 1'($urandom_range(0, 1))});
    end else if (op == OP_ADDI) begin
      seq.push_back('{10, 1'($urandom_range(0, 1))});
      seq.push_back('{11, 1'($urandom_range(0, 1))});
    end
    foreach (seq[i]) begin
      applyStimulus(1'b0, op, z, seq[i].rdy);
      checkOutput("rnd_state", state, seq[i].st);
      checkOutput("rnd_ctrl", dutCtrl, expectCtrl(seq[i].st, op, z, seq[i].rdy));
    end
  endtask

  vec_t vecs[8];
  int   nVec;

  initial begin
    rst = 1'b1; opcode = OP_R; zero = 1'b0; mem_ready = 1'b1;

    // Table of single-instruction paths with memory always ready.
    vecs[0] = '{OP_R,    1'b0, 4, 32'h0000_7610, 1'b0, 1'b1};
    vecs[1] = '{OP_LW,   1'b0, 5, 32'h0004_3210, 1'b0, 1'b1};
    vecs[2] = '{OP_SW,   1'b0, 4, 32'h0000_5210, 1'b0, 1'b0};
    vecs[3] = '{OP_BEQ,  1'b1, 3, 32'h0000_0810, 1'b1, 1'b0};
    vecs[4] = '{OP_BEQ,  1'b0, 3, 32'h0000_0810, 1'b0, 1'b0};
    vecs[5] = '{OP_J,    1'b0, 3, 32'h0000_0910, 1'b1, 1'b0};
    vecs[6] = '{OP_ADDI, 1'b0, 4, 32'h0000_BA10, 1'b0, 1'b1};
    vecs[7] = '{OP_BAD,  1'b0, 2, 32'h0000_0010, 1'b0, 1'b0};
`ifdef CTRL_TRAP_EN
    nVec = 7;
`else
    nVec = 8;
`endif

    // Reset: FETCH with memory ready loads IR and PC.
    doReset();
    applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_mem_read", mem_read, 1);
    checkOutput("rst_pc_en", pc_en, 1);
    checkOutput("rst_ir_write", ir_write, 1);
    checkOutput("rst_reg_write", reg_write, 0);

    // Table-driven paths.
    doReset();
    for (int v = 0; v < nVec; v++) begin
      logic [31:0] p;
      p = vecs[v].path;
      for (int i = 0; i < vecs[v].len; i++) begin
        applyStimulus(1'b0, vecs[v].op, vecs[v].z, 1'b1);
        checkOutput($sformatf("vec%0d_state%0d", v, i), state, p[i*4 +: 4]);
        if (i == vecs[v].len - 1) begin
          checkOutput($sformatf("vec%0d_done", v), instr_done, 1);
          checkOutput($sformatf("vec%0d_pc_en", v), pc_en, vecs[v].pcEnLast);
          checkOutput($sformatf("vec%0d_reg_write", v), reg_write, vecs[v].regWrLast);
        end else begin
          checkOutput($sformatf("vec%0d_nodone%0d", v, i), instr_done, 0);
        end
      end
    end

    // lw with three stall cycles in MEM_RD: 8-cycle latency.
    doReset();
    begin
      int expSt[8] = '{0, 1, 2, 3, 3, 3, 3, 4};
      for (int c = 0; c < 8; c++) begin
        applyStimulus(1'b0, OP_LW, 1'b0, (c >= 3 && c <= 5) ? 1'b0 : 1'b1);
        checkOutput($sformatf("lw_stall_state%0d", c), state, expSt[c]);
        if (c >= 3 && c <= 6) begin
          checkOutput($sformatf("lw_stall_rd%0d", c), {mem_read, iord, mem_write}, 3'b110);
        end
        checkOutput($sformatf("lw_stall_done%0d", c), instr_done, (c == 7) ? 1 : 0);
      end
      checkOutput("lw_stall_m2r", mem_to_reg, 1);
      applyStimulus(1'b0, OP_LW, 1'b0, 1'b1);
      checkOutput("lw_stall_back", state, 0);
    end

    // Reset during a stalled store abandons it.
    doReset();
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b1);
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, OP_SW, 1'b0, 1'b0);
      checkOutput("sw_stall_state", state, 5);
      checkOutput("sw_stall_write", mem_write, 1);
      checkOutput("sw_stall_done", instr_done, 0);
    end
    applyStimulus(1'b1, OP_SW, 1'b0, 1'b0);
    checkOutput("sw_rst_pre", state, 5);
    applyStimulus(1'b0, OP_SW, 1'b0, 1'b0);
    checkOutput("sw_rst_state", state, 0);
    checkOutput("sw_rst_write", mem_write, 0);
    checkOutput("sw_rst_done", instr_done, 0);

    // Illegal opcode.
    doReset();
    applyStimulus(1'b0, OP_BAD, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_BAD, 1'b0, 1'b1);
    checkOutput("bad_decode", state, 1);
    checkOutput("bad_wr", {reg_write, mem_write}, 2'b00);
`ifdef CTRL_TRAP_EN
    checkOutput("bad_decode_done", instr_done, 0);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, OP_BAD, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      checkOutput("trap_state", state, 12);
      checkOutput("trap_flag", illegal_instr, 1);
      checkOutput("trap_ctrl", dutCtrl, 0);
    end
    applyStimulus(1'b1, OP_R, 1'b0, 1'b1);
    applyStimulus(1'b0, OP_R, 1'b0, 1'b1);
    checkOutput("trap_rst_state", state, 0);
    checkOutput("trap_rst_flag", illegal_instr, 0);
`else
    checkOutput("bad_decode_done", instr_done, 1);
    applyStimulus(1'b0, OP_BAD, 1'b0, 1'b1);
    checkOutput("bad_back", state, 0);
    checkOutput("bad_back_wr", {reg_write, mem_write}, 2'b00);
`endif

    // Randomized instruction stream against the phase-list model.
    doReset();
    for (int n = 0; n < 200; n++) begin
      logic [5:0] op;
      int sel;
      sel = $urandom_range(0, 6);
      case (sel)
        0: op = OP_R;
        1: op = OP_LW;
        2: op = OP_SW;
        3: op = OP_BEQ;
        4: op = OP_J;
        5: op = OP_ADDI;
        default: begin
          op = 6'($urandom_range(0, 63));
          if (isLegal(op)) op = OP_BAD;
        end
      endcase
`ifdef CTRL_TRAP_EN
      if (!isLegal(op)) op = OP_ADDI;
`endif
      runModelInstr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
